// File: rtl/fip_sqrt_iter.sv
// Iterative fixed-point square root: digit-by-digit restoring integer sqrt of
// {i_rad, FRA_BITS zeros}, BITS_PER_CYCLE root bits resolved per clock.
//
// state  | meaning
// S_IDLE | waiting for i_en; o_root/o_err hold the last result
// S_RUN  | iterating; i_en ignored until the result strobe
module fip_sqrt_iter #(
   parameter int WIDTH          = 32,
   parameter int FRA_BITS       = 16,
   parameter int BITS_PER_CYCLE = 1,
   parameter int SIGNED         = 1,
   parameter int ROUND          = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_rad,
   output logic [WIDTH-1:0] o_root,
   output logic             o_err,
   output logic             o_busy,
   output logic             o_valid
);

   localparam int OPW = WIDTH + FRA_BITS;
   localparam int N   = OPW / 2;
   localparam int L   = N / BITS_PER_CYCLE;
   localparam int CW  = $clog2(L + 1);

   if (((OPW % 2) != 0) || (FRA_BITS > WIDTH) || ((N % BITS_PER_CYCLE) != 0)) begin : g_param_err
      $error("fip_sqrt_iter: illegal WIDTH/FRA_BITS/BITS_PER_CYCLE combination");
   end

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_valid;
   logic [WIDTH-1:0] r_root;
   logic             r_err;
   logic             r_neg;
   logic [CW-1:0]    r_cnt;
   logic [OPW-1:0]   r_op;
   logic [N+1:0]     r_rem;
   logic [N-1:0]     r_q;

   logic             w_neg_in;
   logic [OPW-1:0]   w_ext;
   logic [OPW-1:0]   w_op_load;
   logic [OPW-1:0]   w_op;
   logic [N+1:0]     w_rem;
   logic [N-1:0]     w_q;
   logic [N+1:0]     w_sh;
   logic [N+1:0]     w_t;
   logic             w_up;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH-1:0] w_res;

   // A negative operand still runs the full schedule on a zero operand so
   // latency never depends on the data.
   assign w_neg_in  = (SIGNED != 0) && i_rad[WIDTH-1];
   assign w_ext     = OPW'(i_rad);
   assign w_op_load = w_neg_in ? '0 : (w_ext << FRA_BITS);

   always_comb begin
      w_rem = r_rem;
      w_q   = r_q;
      w_op  = r_op;
      w_sh  = '0;
      w_t   = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         w_sh = {w_rem[N-1:0], w_op[OPW-1 -: 2]};
         w_t  = {w_q, 2'b01};
         if (w_sh >= w_t) begin
            w_rem = w_sh - w_t;
            w_q   = {w_q[N-2:0], 1'b1};
         end else begin
            w_rem = w_sh;
            w_q   = {w_q[N-2:0], 1'b0};
         end
         w_op = w_op << 2;
      end
   end

   // Round up when the remainder exceeds the floor root; a carry out of
   // WIDTH bits can only happen when N == WIDTH and saturates to all ones.
   assign w_up  = (ROUND != 0) && (w_rem > {2'b00, w_q});
   assign w_sum = {{(WIDTH + 1 - N){1'b0}}, w_q} + {{WIDTH{1'b0}}, w_up};
   assign w_res = r_neg ? '0 : (w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0]);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_root  <= '0;
         r_err   <= 1'b0;
         r_neg   <= 1'b0;
         r_cnt   <= '0;
         r_op    <= '0;
         r_rem   <= '0;
         r_q     <= '0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_en && !r_busy) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b1;
                  r_op    <= w_op_load;
                  r_rem   <= '0;
                  r_q     <= '0;
                  r_neg   <= w_neg_in;
                  r_cnt   <= CW'(L - 1);
               end
            end
            S_RUN: begin
               r_op  <= w_op;
               r_rem <= w_rem;
               r_q   <= w_q;
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b1;
                  r_root  <= w_res;
                  r_err   <= r_neg;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_root  = r_root;
   assign o_err   = r_err;
   assign o_busy  = r_busy;
   assign o_valid = r_valid;

endmodule
